sisc_ctrl_mc: RTL and testbench

//  Next-generation SISC control unit: parametrised multi-cycle FSM driving PC, IR, RF, ALU, status and data memory.

---
 rtl/sisc_pkg.sv | 51 +++++
 rtl/sisc_branch_eval.sv | 42 ++++
 rtl/sisc_ctrl_mc.sv | 197 +++++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sisc_pkg
// Purpose  : Shared constants for the SISC multi-cycle control unit:
//            opcode values, FSM state encoding, alu_op and wb_sel encodings,
//            and a helper that classifies memory-access opcodes.
// Revision : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    // Opcode values (IR[31:28])
    localparam logic [3:0] c_op_noop = 4'h0;
    localparam logic [3:0] c_op_lod  = 4'h1;
    localparam logic [3:0] c_op_str  = 4'h2;
    localparam logic [3:0] c_op_swp  = 4'h3;
    localparam logic [3:0] c_op_bra  = 4'h4;
    localparam logic [3:0] c_op_brr  = 4'h5;
    localparam logic [3:0] c_op_bne  = 4'h6;
    localparam logic [3:0] c_op_bnr  = 4'h7;
    localparam logic [3:0] c_op_alu  = 4'h8;
    localparam logic [3:0] c_op_hlt  = 4'hF;

    // alu_op: [1] = suppress status save, [0] = immediate operand
    localparam logic [1:0] c_alu_reg      = 2'b00;
    localparam logic [1:0] c_alu_imm      = 2'b01;
    localparam logic [1:0] c_alu_nosave   = 2'b10;
    localparam logic [1:0] c_alu_nosave_i = 2'b11;

    // wb_sel: register-file write-data source
    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_rb  = 2'd2;

    typedef enum logic [2:0] {
        ST_START1    = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    // LOD/STR/SWP are the only opcodes that touch data memory
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == c_op_lod) || (op == c_op_str) || (op == c_op_swp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_branch_eval.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sisc_branch_eval
// Purpose  : Combinational branch resolution. A branch is taken when its
//            mask is zero (unconditional) or when the masked status agrees
//            with the branch sense (BRA/BRR: any bit set, BNE/BNR: none set).
// Ports    : opcode   in  4     normalised opcode
//            mm       in  MM_W  condition mask
//            stat     in  MM_W  status register
//            taken    out 1     branch opcode and condition satisfied
//            relative out 1     PC-relative form (BRR/BNR)
// Revision : 1.0 - initial release
// ============================================================================
module sisc_branch_eval
    import sisc_pkg::*;
#(
    parameter int MM_W = 4
) (
    input  logic [3:0]      opcode,
    input  logic [MM_W-1:0] mm,
    input  logic [MM_W-1:0] stat,
    output logic            taken,
    output logic            relative
);

    logic w_cond;
    logic w_uncond;
    logic w_pos;
    logic w_neg;

    assign w_cond   = |(mm & stat);
    assign w_uncond = (mm == '0);
    assign w_pos    = (opcode == c_op_bra) || (opcode == c_op_brr);
    assign w_neg    = (opcode == c_op_bne) || (opcode == c_op_bnr);

    assign taken    = (w_pos && (w_uncond ||  w_cond)) ||
                      (w_neg && (w_uncond || !w_cond));
    assign relative = (opcode == c_op_brr) || (opcode == c_op_bnr);

endmodule
`default_nettype wire

// File: rtl/sisc_ctrl_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sisc_ctrl_mc
// Purpose  : Multi-cycle SISC control unit. Sequences START1 -> FETCH ->
//            DECODE -> EXECUTE -> MEM -> WRITEBACK, with req/rdy wait states
//            in FETCH and MEM, a wait-state timeout, and an absorbing HALT.
// Ports    : clk, rst_f (async active-low); opcode/mm from IR; stat;
//            mem_rdy; datapath enables rf_we, alu_op, wb_sel, br_sel, rb_sel,
//            ir_load, pc_sel, pc_write, pc_rst, mem_req, mem_we; status
//            halted, err (sticky timeout), instr_cnt.
// Config   : SISC_CTRL_PERF_EN - builds the retired-instruction counter;
//            otherwise instr_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_ctrl_mc
    import sisc_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int MM_W    = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OPC_W-1:0] opcode,
    input  logic [MM_W-1:0]  mm,
    input  logic [MM_W-1:0]  stat,
    input  logic             mem_rdy,
    output logic             rf_we,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             br_sel,
    output logic             rb_sel,
    output logic             ir_load,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             pc_rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_err;
    logic [3:0]      w_op;
    logic            w_mem_op;
    logic            w_taken;
    logic            w_relative;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_imm;

    assign w_op     = 4'(opcode);
    assign w_mem_op = is_mem_op(w_op);
    assign w_imm    = (mm == MM_W'(8));

    sisc_branch_eval #(
        .MM_W     (MM_W)
    ) u_branch_eval (
        .opcode   (w_op),
        .mm       (mm),
        .stat     (stat),
        .taken    (w_taken),
        .relative (w_relative)
    );

    // A stalled access is one still waiting on mem_rdy in FETCH or a data MEM.
    // The timeout fires only when the limit is reached and rdy is still low,
    // so a completion in the limit cycle is a normal completion.
    assign w_waiting = !mem_rdy &&
                       ((r_state == ST_FETCH) || ((r_state == ST_MEM) && w_mem_op));
    assign w_timeout = (TIMEOUT > 0) && w_waiting &&
                       (r_wait_cnt == WC_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state    <= ST_START1;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_waiting && !w_timeout)
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;

    always_comb begin
        w_next   = r_state;
        rf_we    = 1'b0;
        alu_op   = c_alu_nosave;
        wb_sel   = c_wb_alu;
        br_sel   = 1'b1;
        rb_sel   = 1'b0;
        ir_load  = 1'b0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_START1: begin
                pc_rst = 1'b1;
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (w_op == c_op_hlt) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_EXECUTE;
                    br_sel = !w_relative;
                    if (w_taken) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            ST_EXECUTE: begin
                if (w_op == c_op_alu)
                    alu_op = w_imm ? c_alu_imm : c_alu_reg;
                else if (w_mem_op)
                    alu_op = c_alu_nosave_i;    // address calculation
                w_next = ST_MEM;
            end
            ST_MEM: begin
                if (w_mem_op) begin
                    mem_req = 1'b1;
                    mem_we  = (w_op != c_op_lod);
                    rb_sel  = (w_op != c_op_lod);
                    if (mem_rdy)
                        w_next = ST_WRITEBACK;
                    else if (w_timeout)
                        w_next = ST_HALT;
                end else begin
                    if (w_op == c_op_alu)
                        alu_op = w_imm ? c_alu_nosave_i : c_alu_nosave;
                    w_next = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                case (w_op)
                    c_op_alu: begin rf_we = 1'b1; wb_sel = c_wb_alu; end
                    c_op_lod: begin rf_we = 1'b1; wb_sel = c_wb_mem; end
                    c_op_swp: begin rf_we = 1'b1; wb_sel = c_wb_rb;  end
                    default:  ;
                endcase
                w_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end
            default: w_next = ST_START1;
        endcase
    end

`ifdef SISC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_instr_cnt;

    // WRITEBACK always returns to FETCH, so each WRITEBACK cycle retires one.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            r_instr_cnt <= '0;
        else if (r_state == ST_WRITEBACK)
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end

    assign instr_cnt = r_instr_cnt;
`else
    assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sisc_ctrl_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sisc_ctrl_mc
// Purpose  : Directed self-checking bench for sisc_ctrl_mc (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sisc_ctrl_mc;

`ifdef SISC_CTRL_PERF_EN
    localparam int c_perf = 1;
`else
    localparam int c_perf = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        mem_rdy;
    logic        rf_we;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        br_sel;
    logic        rb_sel;
    logic        ir_load;
    logic        pc_sel;
    logic        pc_write;
    logic        pc_rst;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        err;
    logic [31:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sisc_ctrl_mc #(
        .OPC_W     (4),
        .MM_W      (4),
        .TIMEOUT   (4),
        .CNT_W     (32)
    ) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .mem_rdy   (mem_rdy),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .br_sel    (br_sel),
        .rb_sel    (rb_sel),
        .ir_load   (ir_load),
        .pc_sel    (pc_sel),
        .pc_write  (pc_write),
        .pc_rst    (pc_rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From FETCH (mem_rdy=1): present instruction, advance into DECODE
    task automatic fetch_to_decode(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
        opcode  = op;
        mm      = m;
        stat    = s;
        mem_rdy = 1'b1;
        tick();
    endtask

    // Branch: check DECODE outputs, then walk EXECUTE/MEM/WRITEBACK back to FETCH
    task automatic run_branch(input string tag, input logic [3:0] op, input logic [3:0] m,
                              input logic [3:0] s, input logic exp_take, input logic exp_brsel);
        fetch_to_decode(op, m, s);
        check_val({tag, "_pc_write"}, pc_write, exp_take);
        check_val({tag, "_pc_sel"}, pc_sel, exp_take);
        if (exp_take)
            check_val({tag, "_br_sel"}, br_sel, exp_brsel);
        tick(); tick(); tick();
        check_val({tag, "_wb_rf_we"}, rf_we, 0);
        tick();
    endtask

    initial begin
        rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; mem_rdy = 1'b0;
        #1;
        check_val("rst_pc_rst", pc_rst, 1);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_err", err, 0);
        check_val("rst_instr_cnt", instr_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_f = 1'b1;
        #1;
        check_val("start1_pc_rst", pc_rst, 1);
        tick();                                     // FETCH

        // ADD (register form)
        opcode = 4'h8; mm = 4'h0; mem_rdy = 1'b1;
        #1;
        check_val("add_f_mem_req", mem_req, 1);
        check_val("add_f_ir_load", ir_load, 1);
        check_val("add_f_pc_write", pc_write, 1);
        check_val("add_f_pc_sel", pc_sel, 0);
        tick();                                     // DECODE
        check_val("add_d_pc_write", pc_write, 0);
        tick();                                     // EXECUTE
        check_val("add_e_alu_op", alu_op, 2'b00);
        tick();                                     // MEM
        check_val("add_m_alu_op", alu_op, 2'b10);
        check_val("add_m_mem_req", mem_req, 0);
        tick();                                     // WRITEBACK
        check_val("add_w_rf_we", rf_we, 1);
        check_val("add_w_wb_sel", wb_sel, 0);
        tick();                                     // FETCH
        check_val("add_instr_cnt", instr_cnt, c_perf ? 1 : 0);

        // ALU immediate form
        fetch_to_decode(4'h8, 4'h8, 4'h0);
        tick();
        check_val("addi_e_alu_op", alu_op, 2'b01);
        tick();
        check_val("addi_m_alu_op", alu_op, 2'b11);
        tick(); tick();

        run_branch("bra", 4'h4, 4'b0010, 4'b0010, 1'b1, 1'b1);
        run_branch("bnr", 4'h7, 4'b0010, 4'b0010, 1'b0, 1'b0);
        run_branch("brr", 4'h5, 4'b0000, 4'b0101, 1'b1, 1'b0);
        run_branch("bne", 4'h6, 4'b0100, 4'b0010, 1'b1, 1'b1);

        // LOD with three wait states in MEM
        begin
            int n_req;
            n_req = 0;
            fetch_to_decode(4'h1, 4'h0, 4'h0);
            tick();                                 // EXECUTE
            check_val("lod_e_alu_op", alu_op, 2'b11);
            mem_rdy = 1'b0;
            tick();                                 // MEM, waiting
            for (int i = 0; i < 3; i++) begin
                if (mem_req) n_req++;
                check_val("lod_m_wait_rf_we", rf_we, 0);
                tick();
            end
            check_val("lod_m_mem_we", mem_we, 0);
            mem_rdy = 1'b1;
            #1;
            if (mem_req) n_req++;
            check_val("lod_mem_req_cycles", n_req, 4);
            tick();                                 // WRITEBACK
            check_val("lod_w_rf_we", rf_we, 1);
            check_val("lod_w_wb_sel", wb_sel, 1);
            tick();
        end

        // SWP
        fetch_to_decode(4'h3, 4'h0, 4'h0);
        tick(); tick();                             // MEM
        check_val("swp_m_mem_req", mem_req, 1);
        check_val("swp_m_mem_we", mem_we, 1);
        check_val("swp_m_rb_sel", rb_sel, 1);
        tick();
        check_val("swp_w_rf_we", rf_we, 1);
        check_val("swp_w_wb_sel", wb_sel, 2);
        tick();

        // STR
        fetch_to_decode(4'h2, 4'h0, 4'h0);
        tick(); tick();
        check_val("str_m_mem_we", mem_we, 1);
        tick();
        check_val("str_w_rf_we", rf_we, 0);
        tick();
        check_val("nine_instr_cnt", instr_cnt, c_perf ? 9 : 0);

        // Reset in the middle of a stalled LOD access
        fetch_to_decode(4'h1, 4'h0, 4'h0);
        tick();
        mem_rdy = 1'b0;
        tick();                                     // MEM
        check_val("mid_mem_req_before", mem_req, 1);
        rst_f = 1'b0;
        #1;
        check_val("mid_rst_mem_req", mem_req, 0);
        check_val("mid_rst_pc_rst", pc_rst, 1);
        check_val("mid_rst_err", err, 0);
        check_val("mid_rst_instr_cnt", instr_cnt, 0);
        tick();
        rst_f = 1'b1;
        mem_rdy = 1'b1;
        tick();                                     // FETCH

        // HLT
        fetch_to_decode(4'hF, 4'h0, 4'h0);
        check_val("hlt_d_halted", halted, 0);
        tick();
        opcode = 4'h8;
        for (int i = 0; i < 3; i++) begin
            check_val("hlt_halted", halted, 1);
            check_val("hlt_enables", {rf_we, ir_load, pc_write, pc_sel, pc_rst, mem_req, mem_we, rb_sel}, 0);
            tick();
        end
        check_val("hlt_err", err, 0);

        // Timeout: mem_rdy stuck low in FETCH
        rst_f = 1'b0;
        #1;
        tick();
        rst_f = 1'b1;
        tick();                                     // FETCH
        mem_rdy = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val("to_f_mem_req", mem_req, 1);
            check_val("to_f_halted", halted, 0);
            tick();
        end
        check_val("to_halted", halted, 1);
        check_val("to_err", err, 1);
        check_val("to_mem_req", mem_req, 0);
        rst_f = 1'b0;
        #1;
        check_val("to_rst_err", err, 0);
        check_val("to_rst_halted", halted, 0);
        tick();
        rst_f = 1'b1;
        tick();                                     // FETCH

        // rdy in the limit cycle completes normally
        mem_rdy = 1'b0;
        repeat (4) tick();
        mem_rdy = 1'b1;
        #1;
        check_val("lim_ir_load", ir_load, 1);
        tick();
        check_val("lim_halted", halted, 0);
        check_val("lim_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
